// File: rtl/mdio_pkg.sv
// ---------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the MDIO command path: FSM state encoding for the
// sequencer, opcode constants used by both the sequencer and the MDIO
// controller, the error pattern returned on a failed transaction, and the
// layout of one queued Clause-22 command.
// ---------------------------------------------------------------------------
package mdio_pkg;

    localparam int PHY_W  = 5;
    localparam int REG_W  = 5;
    localparam int DATA_W = 16;
    localparam int CMD_W  = 1 + PHY_W + REG_W + DATA_W;

    // Sequencer FSM encoding, kept as plain constants so the controller side
    // can share them without enum type coupling.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Clause-22 opcodes as the controller puts them on the wire.
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;

    // Data pattern reported when a transaction times out.
    localparam logic [DATA_W-1:0] ERR_DATA = 16'hFFFF;

    // One FIFO entry: {write, phy, reg, wdata}, write in the MSB.
    typedef struct packed {
        logic              write;
        logic [PHY_W-1:0]  phy;
        logic [REG_W-1:0]  regad;
        logic [DATA_W-1:0] wdata;
    } mdio_cmd_t;

    function automatic mdio_cmd_t pack_cmd(
        input logic              write,
        input logic [PHY_W-1:0]  phy,
        input logic [REG_W-1:0]  regad,
        input logic [DATA_W-1:0] wdata
    );
        mdio_cmd_t c;
        c.write = write;
        c.phy   = phy;
        c.regad = regad;
        c.wdata = wdata;
        return c;
    endfunction

endpackage

// File: rtl/mdio_cmd_fifo.sv
// ---------------------------------------------------------------------------
// mdio_cmd_fifo
// Synchronous single-clock FIFO holding queued MDIO commands.
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   push_i, wdata_i   write request and entry; ignored while full
//   pop_i             remove head entry; ignored while empty
//   rdata_o           current head entry (valid while not empty)
//   full_o, empty_o   occupancy flags, derived from the registered count
//   count_o           number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module mdio_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 27
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok;
    logic             pop_ok;

    // Flags come from the registered count only, so a pop never frees a slot
    // combinationally in the same cycle.
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // Storage array carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mdio_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// mdio_cmd_sequencer
// Queues Clause-22 management requests from the host, hands them one at a
// time to the MDIO controller, supervises each with a timeout and returns
// exactly one response per command, in command order.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready             host command handshake
//   cmd_write, cmd_phy, cmd_reg,
//   cmd_wdata                       command fields
//   rsp_valid/rsp_ready             host response handshake
//   rsp_write, rsp_data, rsp_error  response fields
//   ctl_start                       one-cycle request pulse to controller
//   ctl_write, ctl_phy, ctl_reg,
//   ctl_wdata                       request fields, held for the whole txn
//   ctl_done, ctl_rdata             controller completion and read data
//   busy                            queue non-empty or transaction active
// ---------------------------------------------------------------------------
module mdio_cmd_sequencer
    import mdio_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [PHY_W-1:0]  cmd_phy,
    input  logic [REG_W-1:0]  cmd_reg,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_error,
    output logic              ctl_start,
    output logic              ctl_write,
    output logic [PHY_W-1:0]  ctl_phy,
    output logic [REG_W-1:0]  ctl_reg,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_done,
    input  logic [DATA_W-1:0] ctl_rdata,
    output logic              busy
);

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [1:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    ctl_start_q, ctl_start_d;
    logic                    ctl_write_q, ctl_write_d;
    logic [PHY_W-1:0]        ctl_phy_q, ctl_phy_d;
    logic [REG_W-1:0]        ctl_reg_q, ctl_reg_d;
    logic [DATA_W-1:0]       ctl_wdata_q, ctl_wdata_d;

    logic                    rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
    logic                    rsp_error_q, rsp_error_d;

    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [$clog2(DEPTH):0]  fifo_count;
    logic [CMD_W-1:0]        fifo_rdata;
    mdio_cmd_t               head;

    // cmd_ready is held low during reset so nothing is accepted into a
    // queue that is being cleared.
    assign cmd_ready = !fifo_full && !reset;
    assign fifo_push = cmd_valid && cmd_ready;
    assign head      = mdio_cmd_t'(fifo_rdata);

    mdio_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (pack_cmd(cmd_write, cmd_phy, cmd_reg, cmd_wdata)),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state logic. The counter advances through WAIT and saturates at
    // TIMEOUT. A completion arriving on the same edge that the counter
    // reaches TIMEOUT is still honoured as a success. ctl_done seen in any
    // other state is ignored.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fifo_pop    = 1'b0;
        ctl_start_d = 1'b0;
        ctl_write_d = ctl_write_q;
        ctl_phy_d   = ctl_phy_q;
        ctl_reg_d   = ctl_reg_q;
        ctl_wdata_d = ctl_wdata_q;
        rsp_write_d = rsp_write_q;
        rsp_data_d  = rsp_data_q;
        rsp_error_d = rsp_error_q;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    ctl_write_d = head.write;
                    ctl_phy_d   = head.phy;
                    ctl_reg_d   = head.regad;
                    ctl_wdata_d = head.wdata;
                    ctl_start_d = 1'b1;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cnt_q != TIMEOUT_C) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (ctl_done) begin
                    rsp_write_d = ctl_write_q;
                    rsp_data_d  = ctl_write_q ? {DATA_W{1'b0}} : ctl_rdata;
                    rsp_error_d = 1'b0;
                    state_d     = ST_RESP;
                end else if (cnt_d == TIMEOUT_C) begin
                    rsp_write_d = ctl_write_q;
                    rsp_data_d  = ERR_DATA;
                    rsp_error_d = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset discards any in-flight transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctl_start_q <= 1'b0;
            ctl_write_q <= 1'b0;
            ctl_phy_q   <= '0;
            ctl_reg_q   <= '0;
            ctl_wdata_q <= '0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctl_start_q <= ctl_start_d;
            ctl_write_q <= ctl_write_d;
            ctl_phy_q   <= ctl_phy_d;
            ctl_reg_q   <= ctl_reg_d;
            ctl_wdata_q <= ctl_wdata_d;
            rsp_write_q <= rsp_write_d;
            rsp_data_q  <= rsp_data_d;
            rsp_error_q <= rsp_error_d;
        end
    end

    assign ctl_start = ctl_start_q;
    assign ctl_write = ctl_write_q;
    assign ctl_phy   = ctl_phy_q;
    assign ctl_reg   = ctl_reg_q;
    assign ctl_wdata = ctl_wdata_q;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_write = rsp_write_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_error = rsp_error_q;

    assign busy = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_mdio_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mdio_cmd_sequencer
// Directed bench for the MDIO command sequencer with a small controller
// model that answers each ctl_start after a programmable delay.
// ---------------------------------------------------------------------------
module tb_mdio_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [4:0]  cmd_phy;
    logic [4:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [15:0] rsp_data;
    logic        rsp_error;
    logic        ctl_start;
    logic        ctl_write;
    logic [4:0]  ctl_phy;
    logic [4:0]  ctl_reg;
    logic [15:0] ctl_wdata;
    logic        ctl_done;
    logic [15:0] ctl_rdata;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mdio_cmd_sequencer #(
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_phy   (cmd_phy),
        .cmd_reg   (cmd_reg),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_data  (rsp_data),
        .rsp_error (rsp_error),
        .ctl_start (ctl_start),
        .ctl_write (ctl_write),
        .ctl_phy   (ctl_phy),
        .ctl_reg   (ctl_reg),
        .ctl_wdata (ctl_wdata),
        .ctl_done  (ctl_done),
        .ctl_rdata (ctl_rdata),
        .busy      (busy)
    );

    // Controller model: after seeing ctl_start it raises done modelDelay
    // edges later (0 = never answer). In echo mode read data is derived from
    // the request fields so the order of responses can be checked.
    int          modelDelay = 0;
    bit          modelEcho  = 1'b0;
    logic [15:0] modelRdata = 16'h0000;
    bit          spurDone   = 1'b0;
    bit          modelActive;
    int          modelCnt;
    logic        modelDone;

    assign ctl_done = modelDone | spurDone;

    always @(posedge clk) begin
        if (reset) begin
            modelActive <= 1'b0;
            modelCnt    <= 0;
            modelDone   <= 1'b0;
            ctl_rdata   <= 16'h0000;
        end else begin
            modelDone <= 1'b0;
            if (ctl_start) begin
                modelActive <= (modelDelay != 0);
                modelCnt    <= 0;
            end else if (modelActive) begin
                if (modelCnt + 1 == modelDelay) begin
                    modelDone   <= 1'b1;
                    modelActive <= 1'b0;
                    ctl_rdata   <= modelEcho ? {ctl_phy, ctl_reg, 6'h15} : modelRdata;
                end
                modelCnt <= modelCnt + 1;
            end
        end
    end

    // Edge counter plus logs of starts and accepted responses.
    int          edgeCount  = 0;
    int          startEdge  = 0;
    int          startCount = 0;
    int          rspCount   = 0;
    logic [15:0] rspDataLog[$];
    bit          rspWriteLog[$];
    bit          rspErrLog[$];

    always @(posedge clk) begin
        edgeCount++;
        if (!reset && ctl_start) begin
            startEdge = edgeCount;
            startCount++;
        end
        if (!reset && rsp_valid && rsp_ready) begin
            rspCount++;
            rspDataLog.push_back(rsp_data);
            rspWriteLog.push_back(rsp_write);
            rspErrLog.push_back(rsp_error);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Present one command and hold it until accepted (bounded).
    task automatic applyStimulus(input bit wr, input logic [4:0] phy,
                                 input logic [4:0] rg, input logic [15:0] wd);
        int n = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_phy   = phy;
        cmd_reg   = rg;
        cmd_wdata = wd;
        while (!cmd_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checkOutput("push_accept", 32'd0, 32'd1);
        end else begin
            @(posedge clk);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic waitRsp(input string tag, input int limit, output int lat);
        int n = 0;
        @(negedge clk);
        while (!rsp_valid && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checkOutput(tag, 32'd0, 32'd1);
        end
        lat = edgeCount - startEdge;
    endtask

    task automatic takeRsp();
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        bit          wr;
        logic [4:0]  phy;
        logic [4:0]  rg;
        logic [15:0] wd;
    } cmd_vec_t;

    initial begin
        int          lat;
        int          base;
        int          sbase;
        int          n;
        bit          seen;
        logic [15:0] expData;
        cmd_vec_t    stream[5];

        stream[0] = '{1'b1, 5'h02, 5'h04, 16'h1234};
        stream[1] = '{1'b0, 5'h03, 5'h05, 16'h0000};
        stream[2] = '{1'b1, 5'h04, 5'h06, 16'hABCD};
        stream[3] = '{1'b0, 5'h05, 5'h07, 16'h0000};
        stream[4] = '{1'b0, 5'h06, 5'h08, 16'h0000};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_phy   = '0;
        cmd_reg   = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b0;

        // Reset values, and cmd_ready held low while reset is high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_flags", {27'd0, ctl_start, rsp_valid, rsp_error, busy, rsp_write}, 32'd0);
        checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_ctl_fields", 32'({ctl_write, ctl_phy, ctl_reg, ctl_wdata}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

        // Single write, controller answers after 70 cycles.
        $display("[TB] single write");
        modelDelay = 70;
        applyStimulus(1'b1, 5'h01, 5'h00, 16'h8000);
        @(negedge clk);
        checkOutput("wr_start_early", 32'(ctl_start), 32'd0);
        @(negedge clk);
        checkOutput("wr_start", 32'(ctl_start), 32'd1);
        checkOutput("wr_fields", 32'({ctl_write, ctl_phy, ctl_reg, ctl_wdata}),
                    32'({1'b1, 5'h01, 5'h00, 16'h8000}));
        checkOutput("wr_busy", 32'(busy), 32'd1);
        waitRsp("wr_rsp_wait", 400, lat);
        checkOutput("wr_latency", 32'(lat), 32'd71);
        checkOutput("wr_rsp", {15'd0, rsp_write, rsp_data}, {15'd0, 1'b1, 16'h0000});
        checkOutput("wr_err", 32'(rsp_error), 32'd0);
        takeRsp();
        checkOutput("wr_rsp_cleared", 32'(rsp_valid), 32'd0);

        // Single read returning a fixed value.
        $display("[TB] single read");
        modelDelay = 10;
        modelRdata = 16'h0141;
        applyStimulus(1'b0, 5'h1F, 5'h02, 16'hDEAD);
        waitRsp("rd_rsp_wait", 400, lat);
        checkOutput("rd_latency", 32'(lat), 32'd11);
        checkOutput("rd_rsp", {15'd0, rsp_write, rsp_data}, {15'd0, 1'b0, 16'h0141});
        checkOutput("rd_err", 32'(rsp_error), 32'd0);
        takeRsp();

        // Five back-to-back commands into a depth-4 queue.
        $display("[TB] stream of five");
        modelDelay = 3;
        modelEcho  = 1'b1;
        rsp_ready  = 1'b1;
        rspDataLog.delete();
        rspWriteLog.delete();
        rspErrLog.delete();
        base  = rspCount;
        sbase = startCount;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(stream[i].wr, stream[i].phy, stream[i].rg, stream[i].wd);
        end
        @(negedge clk);
        checkOutput("stream_full", 32'(cmd_ready), 32'd0);
        n = 0;
        while (rspCount - base < 5 && n < 600) begin
            @(negedge clk);
            n++;
        end
        checkOutput("stream_rsp_count", 32'(rspCount - base), 32'd5);
        checkOutput("stream_start_count", 32'(startCount - sbase), 32'd5);
        for (int i = 0; i < 5 && i < rspDataLog.size(); i++) begin
            expData = stream[i].wr ? 16'h0000 : {stream[i].phy, stream[i].rg, 6'h15};
            checkOutput($sformatf("stream_rsp%0d", i),
                        {14'd0, rspErrLog[i], rspWriteLog[i], rspDataLog[i]},
                        {14'd0, 1'b0, stream[i].wr, expData});
        end
        rsp_ready = 1'b0;
        modelEcho = 1'b0;
        @(negedge clk);
        checkOutput("stream_idle", 32'(busy), 32'd0);

        // Controller never answers: timeout after exactly TIMEOUT WAIT cycles.
        $display("[TB] timeout");
        modelDelay = 0;
        applyStimulus(1'b0, 5'h07, 5'h09, 16'h0000);
        waitRsp("to_rsp_wait", 600, lat);
        checkOutput("to_latency", 32'(lat), 32'(TIMEOUT));
        checkOutput("to_rsp", {14'd0, rsp_error, rsp_write, rsp_data}, {14'd0, 1'b1, 1'b0, 16'hFFFF});
        takeRsp();

        // The next command behaves normally.
        modelDelay = 5;
        modelRdata = 16'h5A5A;
        applyStimulus(1'b0, 5'h08, 5'h0A, 16'h0000);
        waitRsp("after_to_wait", 400, lat);
        checkOutput("after_to_latency", 32'(lat), 32'd6);
        checkOutput("after_to_rsp", {15'd0, rsp_error, rsp_data}, {15'd0, 1'b0, 16'h5A5A});
        takeRsp();

        // Completion lands on the same edge the counter reaches TIMEOUT.
        $display("[TB] done on timeout edge");
        modelDelay = TIMEOUT - 1;
        modelRdata = 16'h1357;
        applyStimulus(1'b0, 5'h09, 5'h0B, 16'h0000);
        waitRsp("edge_wait", 600, lat);
        checkOutput("edge_latency", 32'(lat), 32'(TIMEOUT));
        checkOutput("edge_rsp", {15'd0, rsp_error, rsp_data}, {15'd0, 1'b0, 16'h1357});
        takeRsp();

        // Spurious completion while idle produces nothing.
        $display("[TB] spurious done");
        sbase = startCount;
        seen  = 1'b0;
        @(negedge clk);
        spurDone = 1'b1;
        @(negedge clk);
        spurDone = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid | busy;
        end
        checkOutput("spur_no_rsp", 32'(seen), 32'd0);
        checkOutput("spur_no_start", 32'(startCount - sbase), 32'd0);

        // Reset while waiting with two commands still queued.
        $display("[TB] reset mid-transaction");
        modelDelay = 0;
        applyStimulus(1'b1, 5'h0A, 5'h01, 16'h1111);
        applyStimulus(1'b0, 5'h0B, 5'h02, 16'h0000);
        applyStimulus(1'b1, 5'h0C, 5'h03, 16'h3333);
        repeat (3) @(negedge clk);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_flags",
                    {26'd0, cmd_ready, ctl_start, rsp_valid, rsp_error, busy, rsp_write}, 32'd0);
        checkOutput("mid_rst_data", {rsp_data, 16'(ctl_wdata)}, 32'd0);
        checkOutput("mid_rst_addr", 32'({ctl_write, ctl_phy, ctl_reg}), 32'd0);
        reset     = 1'b0;
        rsp_ready = 1'b1;
        base      = rspCount;
        sbase     = startCount;
        seen      = 1'b0;
        @(negedge clk);
        checkOutput("mid_post_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            seen = seen | rsp_valid | busy;
        end
        checkOutput("mid_no_activity", 32'(seen), 32'd0);
        checkOutput("mid_no_rsp", 32'(rspCount - base), 32'd0);
        checkOutput("mid_no_start", 32'(startCount - sbase), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
